reset_enable_responder: RTL and testbench

RESET_ENABLE_RESPONDER -- requirements
Module: reset_enable_responder

---
 rtl/reset_enable_responder.sv | 82 ++++++++
 tb/tb_reset_enable_responder.sv | 115 +++++++++++
 2 files changed

// File: rtl/reset_enable_responder.sv
// reset_enable_responder: four-phase enable handshake sequencing a domain reset with quiesce and timeout
module reset_enable_responder #(
  parameter int ASSERT_HOLD     = 4,
  parameter int RELEASE_DELAY   = 3,
  parameter int QUIESCE_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable_req,
  input  logic       quiesce_ack,
  output logic       enable_ack,
  output logic       domain_reset,
  output logic       quiesce_req,
  output logic       quiesce_timeout,
  output logic [2:0] state
);
  typedef enum logic [1:0] {RESET_HELD, RELEASING, RUNNING, QUIESCING} state_t;
  localparam logic [15:0] HOLD_END = 16'(ASSERT_HOLD);
  localparam logic [15:0] REL_END  = 16'(RELEASE_DELAY - 1);
  localparam logic [15:0] QTO_END  = 16'(QUIESCE_TIMEOUT - 1);
  localparam bit          QTO_ON   = QUIESCE_TIMEOUT != 0;
  state_t      r_state, w_next;
  logic [15:0] r_cnt, w_cnt;
  logic        r_ack, r_dr, r_qr, r_to;
  logic        w_ack, w_to, w_hold_done;
  // next state, counter and acknowledge; outputs are registered from the next state
  always_comb begin
    w_next      = r_state;
    w_cnt       = r_cnt + 16'd1;
    w_ack       = r_ack;
    w_to        = 1'b0;
    w_hold_done = r_cnt == HOLD_END;
    case (r_state)
      RESET_HELD: begin
        w_cnt = w_hold_done ? r_cnt : r_cnt + 16'd1;
        w_ack = w_hold_done ? 1'b0 : r_ack;
        if (w_hold_done && !r_ack && enable_req) w_next = RELEASING;
      end
      RELEASING: begin
        if (!enable_req) w_next = RESET_HELD;
        else if (r_cnt == REL_END) begin
          w_next = RUNNING;
          w_ack  = 1'b1;
        end
      end
      RUNNING: if (!enable_req) w_next = QUIESCING;
      QUIESCING: begin
        w_cnt = QTO_ON ? r_cnt + 16'd1 : r_cnt;
        if (quiesce_ack) w_next = RESET_HELD;
        else if (QTO_ON && r_cnt == QTO_END) begin
          w_next = RESET_HELD;
          w_to   = 1'b1;
        end
      end
      default: w_next = RESET_HELD;
    endcase
    if (w_next != r_state) w_cnt = 16'd0;
  end
  // state, counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RESET_HELD;
      r_cnt   <= 16'd0;
      r_ack   <= 1'b0;
      r_dr    <= 1'b1;
      r_qr    <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_ack   <= w_ack;
      r_dr    <= w_next == RESET_HELD;
      r_qr    <= w_next == QUIESCING;
      r_to    <= w_to;
    end
  end
  assign enable_ack      = r_ack;
  assign domain_reset    = r_dr;
  assign quiesce_req     = r_qr;
  assign quiesce_timeout = r_to;
  assign state           = {1'b0, r_state};
endmodule

// File: tb/tb_reset_enable_responder.sv
// tb_reset_enable_responder: randomized scoreboard check against a level-based reference model
module tb_reset_enable_responder;
  localparam int AH = 4;
  localparam int RD = 3;
  localparam int QT = 8;
  typedef struct packed {
    logic [2:0] st;
    logic       dr;
    logic       ack;
    logic       qr;
    logic       to;
  } obs_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       qa  = 1'b0;
  logic       enable_ack, domain_reset, quiesce_req, quiesce_timeout;
  logic [2:0] state;
  obs_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  bit         m_dr = 1'b1, m_ack = 1'b0, m_qr = 1'b0, m_to = 1'b0;
  int         m_age = 0, m_rel = 0, m_q = 0;
  reset_enable_responder #(.ASSERT_HOLD(AH), .RELEASE_DELAY(RD), .QUIESCE_TIMEOUT(QT)) dut (
    .clock(clk), .reset(rst), .enable_req(req), .quiesce_ack(qa),
    .enable_ack(enable_ack), .domain_reset(domain_reset), .quiesce_req(quiesce_req),
    .quiesce_timeout(quiesce_timeout), .state(state)
  );
  always #5 clk = ~clk;
  // reference: the domain is described by its output levels and the age of the current phase
  function automatic logic [2:0] m_state();
    return m_dr ? 3'd0 : m_qr ? 3'd3 : m_ack ? 3'd2 : 3'd1;
  endfunction
  task automatic model(input bit r, input bit e, input bit a);
    m_to = 1'b0;
    if (r) begin
      m_dr = 1'b1; m_ack = 1'b0; m_qr = 1'b0; m_age = 0;
    end else if (m_dr) begin
      if (m_age == AH) begin
        if (m_ack) m_ack = 1'b0;
        else if (e) begin m_dr = 1'b0; m_rel = 0; end
      end else m_age++;
    end else if (m_qr) begin
      if (a || (QT > 0 && m_q == QT - 1)) begin
        m_to = !a; m_qr = 1'b0; m_dr = 1'b1; m_age = 0;
      end else if (QT > 0) m_q++;
    end else if (m_ack) begin
      if (!e) begin m_qr = 1'b1; m_q = 0; end
    end else begin
      if (!e) begin m_dr = 1'b1; m_age = 0; end
      else if (m_rel == RD - 1) m_ack = 1'b1;
      else m_rel++;
    end
  endtask
  task automatic step(input bit r, input bit e, input bit a);
    @(negedge clk);
    rst = r; req = e; qa = a;
    @(posedge clk);
    model(r, e, a);
    exp_q.push_back('{st: m_state(), dr: m_dr, ack: m_ack, qr: m_qr, to: m_to});
  endtask
  // monitor: every cycle the DUT presents a full output set that is checked against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, g;
      e = exp_q.pop_front();
      g = '{st: state, dr: domain_reset, ack: enable_ack, qr: quiesce_req, to: quiesce_timeout};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d got st=%0d dr=%b ack=%b qr=%b to=%b exp st=%0d dr=%b ack=%b qr=%b to=%b",
                 cyc, g.st, g.dr, g.ack, g.qr, g.to, e.st, e.dr, e.ack, e.qr, e.to);
      end
      cyc++;
    end
  end
  initial begin
    bit r, e, a;
    int n;
    step(1, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    e = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 9) == 0) e = !e;
      a = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      step(r, e, a);
    end
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
